data_table_ram_arb: RTL and testbench
=====================================

Name: data_table_ram_arb

Overview:
- Round-robin arbiter that shares the single-read/single-write data-table RAM among REQ_CNT engines (init, search, insert, delete).
- It replaces the fixed priority mux. Engines can run concurrently without corrupting RAM accesses.
- Read and write ports are arbitrated independently.
- Read data is returned to the requester that issued the read, using an internal tag pipeline matched to RAM_LATENCY.

Parameters:
REQ_CNT, 4, number of requesting engines (≥2)
A_WIDTH, 10, RAM address width (HEAD_PTR_WIDTH)
D_WIDTH, 64, RAM word width ($bits(ram_data_t))
RAM_LATENCY, 2, cycles from RAM read address to valid q (registered-output RAM)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
rd_req_i  input  REQ_CNT  per-engine read request
rd_addr_i  input  REQ_CNT*A_WIDTH  per-engine read address, packed, engine i at [i*A_WIDTH +: A_WIDTH]
rd_gnt_o  output  REQ_CNT  one-hot read grant
rd_data_o  output  D_WIDTH  read data, broadcast to all engines
rd_data_val_o  output  REQ_CNT  one-hot read data valid
wr_req_i  input  REQ_CNT  per-engine write request
wr_addr_i  input  REQ_CNT*A_WIDTH  per-engine write address, packed
wr_data_i  input  REQ_CNT*D_WIDTH  per-engine write data, packed
wr_gnt_o  output  REQ_CNT  one-hot write grant
ram_rd_addr_o  output  A_WIDTH  to RAM port A address
ram_rd_data_i  input  D_WIDTH  from RAM port A q
ram_wr_addr_o  output  A_WIDTH  to RAM port B address
ram_wr_data_o  output  D_WIDTH  to RAM port B data
ram_wr_en_o  output  1  to RAM port B we

Behaviour:
- Clock and reset: clk_i only. Reset is synchronous, active-high, on rst_i.
- Reset values: rd_rr_ptr = 0 and wr_rr_ptr = 0. Tag pipeline valid bits = 0. rd_data_val_o = 0 and ram_wr_en_o = 0 from the first cycle after rst_i is sampled.
- Grant logic:
  - Grants are combinational from the requests and the registered rr pointer.
  - Search starts at index rr_ptr and wraps modulo REQ_CNT. The first set request wins.
  - At most one grant bit is set per port.
- Handshake:
  - A request is held, with stable address/data, until the cycle its grant is seen. Transfer occurs in the cycle where req && gnt.
  - Engines must not depend on gnt to drive req, so there is no combinational loop.
- Pointer update: on a granted transfer, rr_ptr <= (granted_idx + 1) mod REQ_CNT. With no grant, rr_ptr holds.
- Write path:
  - ram_wr_en_o = |wr_gnt_o.
  - ram_wr_addr_o and ram_wr_data_o are muxed from the granted engine; they are 0 when idle.
  - Zero added latency.
- Read path:
  - ram_rd_addr_o is muxed from the granted engine; it holds its last value when idle.
  - The tag pipeline has RAM_LATENCY stages. Each stage holds {valid, idx}; stage 0 loads {|rd_gnt_o, granted_idx}.
  - rd_data_val_o[idx] = final stage valid. rd_data_val_o rises exactly RAM_LATENCY cycles after the grant cycle.
  - rd_data_o = ram_rd_data_i, passed through, not registered.
- Back-to-back: one read and one write can be granted every cycle, so full throughput. Different engines may hold rd and wr grants in the same cycle.
- Same-address read and write in one cycle: no forwarding. The read returns the old word (read-during-write old-data RAM). Engines own their ordering.
- Single requester: it is granted every cycle with no bubbles.
- Reset mid-operation: in-flight tags are discarded. No rd_data_val_o is asserted for reads granted before reset.
- REQ_CNT not a power of two: pointer wrap uses an explicit compare to REQ_CNT-1, never bit truncation.

Optional Feature:
Macro: DATA_TABLE_ARB_LOCK_EN
- With the macro defined:
  - Adds input lock_i [REQ_CNT].
  - If engine k is granted (either port) while lock_i[k] = 1, a lock owner register is set to k. While the lock is held, only k can be granted on both ports; other requests wait.
  - The lock releases on the first cycle lock_i[k] = 0.
  - Reset clears the lock.
  - Purpose: atomic read-modify-write chains in delete/insert.
- Without the macro: no lock_i port and no lock register. Pure round-robin.

Decomposition:
- Package hash_table gains:
  - DT_ARB_REQ_CNT = 4
  - typedef logic [$clog2(DT_ARB_REQ_CNT)-1:0] dt_req_idx_t
  - dt_rd_tag_t struct {logic val; dt_req_idx_t idx;}
- Sub-module rr_arbiter (parameter REQ_CNT; ports clk_i, rst_i, req_i, gnt_o, gnt_idx_o) holds the pointer and the priority search. It is instantiated twice, once for read and once for write.

Test Plan:
- Single read, REQ_CNT=4, RAM_LATENCY=2: engine 2 reads addr 0x15 at cycle 10 -> rd_gnt_o = 4'b0100 at cycle 10; rd_data_val_o = 4'b0100 at cycle 12 with the word at 0x15.
- Fairness: all four rd_req_i held high for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3; each engine gets exactly 2 data valids, in the same order.
- Concurrent ports: engine 1 writes 0xAB to addr 3 while engine 3 reads addr 7 in the same cycle -> both granted; ram_wr_en_o = 1 with addr 3; read data valid to engine 3 two cycles later.
- Read-during-write: addr 5 holds 0x11; write 0x22 and read addr 5 in the same cycle -> read returns 0x11; a read one cycle later returns 0x22.
- Reset mid-flight: grant a read, assert rst_i the next cycle -> rd_data_val_o stays 0; rr pointers restart at 0 (first grant after reset goes to engine 0 when all request).
- Lock (DATA_TABLE_ARB_LOCK_EN): engine 3 locks, then engines 0 and 3 request for 4 cycles -> only engine 3 is granted; after lock_i[3] drops, engine 0 is granted the next cycle.

Source files
------------

// File: rtl/data_table_ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// data_table_ram_arb_pkg
//   Shared constants and types for the data-table RAM arbiter.
//   - DT_ARB_* localparams give the default engine count, RAM address and
//     data widths, and RAM read latency used by the arbiter and its interface.
//   - dt_req_idx_t is the engine index type for the default engine count.
//   - dt_rd_tag_t is one stage of the read-return tag pipeline.
// ---------------------------------------------------------------------------
package data_table_ram_arb_pkg;

    localparam int DT_ARB_REQ_CNT     = 4;
    localparam int DT_ARB_A_WIDTH     = 10;
    localparam int DT_ARB_D_WIDTH     = 64;
    localparam int DT_ARB_RAM_LATENCY = 2;

    typedef logic [$clog2(DT_ARB_REQ_CNT)-1:0] dt_req_idx_t;

    typedef struct packed {
        logic        val;
        dt_req_idx_t idx;
    } dt_rd_tag_t;

endpackage

// File: rtl/data_table_ram_arb_if.sv
// ---------------------------------------------------------------------------
// data_table_ram_arb_if
//   Engine-side bus of the data-table RAM arbiter. All per-engine fields are
//   packed with engine i in slice [i*W +: W].
//   Signals:
//     rd_req      per-engine read request
//     rd_addr     per-engine read address
//     rd_gnt      one-hot read grant
//     rd_data     read data, broadcast to all engines
//     rd_data_val one-hot read data valid
//     wr_req      per-engine write request
//     wr_addr     per-engine write address
//     wr_data     per-engine write data
//     wr_gnt      one-hot write grant
//   Modports:
//     master  the engines (drive requests, receive grants and data)
//     slave   the arbiter
// ---------------------------------------------------------------------------
interface data_table_ram_arb_if
    import data_table_ram_arb_pkg::*;
#(
    parameter int REQ_CNT = DT_ARB_REQ_CNT,
    parameter int A_WIDTH = DT_ARB_A_WIDTH,
    parameter int D_WIDTH = DT_ARB_D_WIDTH
);

    logic [REQ_CNT-1:0]         rd_req;
    logic [REQ_CNT*A_WIDTH-1:0] rd_addr;
    logic [REQ_CNT-1:0]         rd_gnt;
    logic [D_WIDTH-1:0]         rd_data;
    logic [REQ_CNT-1:0]         rd_data_val;

    logic [REQ_CNT-1:0]         wr_req;
    logic [REQ_CNT*A_WIDTH-1:0] wr_addr;
    logic [REQ_CNT*D_WIDTH-1:0] wr_data;
    logic [REQ_CNT-1:0]         wr_gnt;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_data, rd_data_val, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_data, rd_data_val, wr_gnt
    );

endinterface

// File: rtl/data_table_ram_arb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter for one RAM port. The search starts at the registered
//   pointer and wraps; the first set request wins. After a grant the pointer
//   moves to one past the winner, otherwise it holds.
//   Ports:
//     clk_i      clock
//     rst_i      synchronous active-high reset (pointer back to 0)
//     req_i      per-requester request
//     gnt_o      one-hot grant (combinational)
//     gnt_idx_o  index of the granted requester (0 when idle)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int REQ_CNT = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [REQ_CNT-1:0]         req_i,
    output logic [REQ_CNT-1:0]         gnt_o,
    output logic [$clog2(REQ_CNT)-1:0] gnt_idx_o
);

    localparam int IDX_W = $clog2(REQ_CNT);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [IDX_W:0]   cand_sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Wrap-around priority search. The candidate sum carries one extra bit so
    // the wrap is an explicit subtract of REQ_CNT, valid for any REQ_CNT.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand_sum  = '0;
        cand      = '0;
        for (int off = 0; off < REQ_CNT; off++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(off);
            if (cand_sum >= (IDX_W+1)'(REQ_CNT)) begin
                cand_sum = cand_sum - (IDX_W+1)'(REQ_CNT);
            end
            cand = cand_sum[IDX_W-1:0];
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

    // Pointer wrap compares against the last index instead of truncating.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (found) begin
            rr_ptr_d = (gnt_idx_o == IDX_W'(REQ_CNT - 1)) ? '0 : gnt_idx_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/data_table_ram_arb.sv
// ---------------------------------------------------------------------------
// data_table_ram_arb
//   Shares the single-read/single-write data-table RAM among REQ_CNT engines.
//   Read and write ports each have their own round-robin arbiter, so one read
//   and one write can be granted every cycle. Read data returns RAM_LATENCY
//   cycles after the grant, steered to the issuing engine by a tag pipeline.
//   Ports:
//     clk_i, rst_i     clock, synchronous active-high reset
//     eng              engine bus (slave modport of data_table_ram_arb_if)
//     lock_i           per-engine lock request (only with the macro below)
//     ram_rd_addr_o    RAM port A address (holds last value when idle)
//     ram_rd_data_i    RAM port A q, passed straight to eng.rd_data
//     ram_wr_addr_o    RAM port B address (0 when idle)
//     ram_wr_data_o    RAM port B data (0 when idle)
//     ram_wr_en_o      RAM port B write enable
//   Build option:
//     DATA_TABLE_ARB_LOCK_EN  adds lock_i; an engine granted while its lock
//     bit is set becomes lock owner and is the only engine granted on either
//     port until its lock bit drops. Undefined: pure round-robin.
// ---------------------------------------------------------------------------
module data_table_ram_arb
    import data_table_ram_arb_pkg::*;
#(
    parameter int REQ_CNT     = DT_ARB_REQ_CNT,
    parameter int A_WIDTH     = DT_ARB_A_WIDTH,
    parameter int D_WIDTH     = DT_ARB_D_WIDTH,
    parameter int RAM_LATENCY = DT_ARB_RAM_LATENCY
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    data_table_ram_arb_if.slave  eng,
`ifdef DATA_TABLE_ARB_LOCK_EN
    input  logic [REQ_CNT-1:0]   lock_i,
`endif
    output logic [A_WIDTH-1:0]   ram_rd_addr_o,
    input  logic [D_WIDTH-1:0]   ram_rd_data_i,
    output logic [A_WIDTH-1:0]   ram_wr_addr_o,
    output logic [D_WIDTH-1:0]   ram_wr_data_o,
    output logic                 ram_wr_en_o
);

    localparam int IDX_W = $clog2(REQ_CNT);

    // Same layout as dt_rd_tag_t, sized for this instance's engine count.
    typedef struct packed {
        logic             val;
        logic [IDX_W-1:0] idx;
    } rd_tag_t;

    logic [REQ_CNT-1:0] rd_req_eff;
    logic [REQ_CNT-1:0] wr_req_eff;
    logic [REQ_CNT-1:0] rd_gnt;
    logic [REQ_CNT-1:0] wr_gnt;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   wr_idx;

    logic [A_WIDTH-1:0] ram_rd_addr_q;
    logic [A_WIDTH-1:0] ram_rd_addr_d;
    logic [A_WIDTH-1:0] rd_addr_mux;

    rd_tag_t [RAM_LATENCY-1:0] tag_q;
    rd_tag_t [RAM_LATENCY-1:0] tag_d;

`ifdef DATA_TABLE_ARB_LOCK_EN
    logic               lock_held_q;
    logic               lock_held_d;
    logic [IDX_W-1:0]   lock_owner_q;
    logic [IDX_W-1:0]   lock_owner_d;
    logic [REQ_CNT-1:0] owner_mask;

    // While a lock is held, only the owner's requests reach the arbiters.
    always_comb begin
        owner_mask               = '0;
        owner_mask[lock_owner_q] = 1'b1;
        rd_req_eff               = eng.rd_req;
        wr_req_eff               = eng.wr_req;
        if (lock_held_q) begin
            rd_req_eff = eng.rd_req & owner_mask;
            wr_req_eff = eng.wr_req & owner_mask;
        end
    end

    // Release is seen on the first cycle the owner drops its lock bit; a new
    // lock can only be taken from a cycle that started unlocked. Read grant
    // takes precedence if both ports grant locking engines together.
    always_comb begin
        lock_held_d  = lock_held_q;
        lock_owner_d = lock_owner_q;
        if (lock_held_q && !lock_i[lock_owner_q]) begin
            lock_held_d = 1'b0;
        end
        if (!lock_held_q) begin
            if (|rd_gnt && lock_i[rd_idx]) begin
                lock_held_d  = 1'b1;
                lock_owner_d = rd_idx;
            end else if (|wr_gnt && lock_i[wr_idx]) begin
                lock_held_d  = 1'b1;
                lock_owner_d = wr_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_held_q  <= 1'b0;
            lock_owner_q <= '0;
        end else begin
            lock_held_q  <= lock_held_d;
            lock_owner_q <= lock_owner_d;
        end
    end
`else
    assign rd_req_eff = eng.rd_req;
    assign wr_req_eff = eng.wr_req;
`endif

    rr_arbiter #(
        .REQ_CNT (REQ_CNT)
    ) u_rd_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (rd_req_eff),
        .gnt_o     (rd_gnt),
        .gnt_idx_o (rd_idx)
    );

    rr_arbiter #(
        .REQ_CNT (REQ_CNT)
    ) u_wr_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (wr_req_eff),
        .gnt_o     (wr_gnt),
        .gnt_idx_o (wr_idx)
    );

    assign eng.rd_gnt  = rd_gnt;
    assign eng.wr_gnt  = wr_gnt;
    assign eng.rd_data = ram_rd_data_i;

    // Write port: straight mux from the granted engine, zero when idle.
    always_comb begin
        ram_wr_addr_o = '0;
        ram_wr_data_o = '0;
        for (int i = 0; i < REQ_CNT; i++) begin
            if (wr_gnt[i]) begin
                ram_wr_addr_o = eng.wr_addr[i*A_WIDTH +: A_WIDTH];
                ram_wr_data_o = eng.wr_data[i*D_WIDTH +: D_WIDTH];
            end
        end
    end

    assign ram_wr_en_o = |wr_gnt;

    // Read port: the address holds its last granted value when idle so the
    // RAM address pins do not toggle needlessly.
    always_comb begin
        rd_addr_mux = '0;
        for (int i = 0; i < REQ_CNT; i++) begin
            if (rd_gnt[i]) begin
                rd_addr_mux = eng.rd_addr[i*A_WIDTH +: A_WIDTH];
            end
        end
        ram_rd_addr_d = (|rd_gnt) ? rd_addr_mux : ram_rd_addr_q;
    end

    assign ram_rd_addr_o = ram_rd_addr_d;

    // Tag pipeline, one stage per cycle of RAM read latency.
    always_comb begin
        tag_d        = tag_q;
        tag_d[0].val = |rd_gnt;
        tag_d[0].idx = rd_idx;
        for (int s = 1; s < RAM_LATENCY; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    // Reset flushes every in-flight tag, so reads granted before reset never
    // produce a data valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_q         <= '0;
            ram_rd_addr_q <= '0;
        end else begin
            tag_q         <= tag_d;
            ram_rd_addr_q <= ram_rd_addr_d;
        end
    end

    always_comb begin
        eng.rd_data_val = '0;
        if (tag_q[RAM_LATENCY-1].val) begin
            eng.rd_data_val[tag_q[RAM_LATENCY-1].idx] = 1'b1;
        end
    end

endmodule

// File: tb/tb_data_table_ram_arb.sv
// ---------------------------------------------------------------------------
// tb_data_table_ram_arb
//   Bench for data_table_ram_arb with a registered-output RAM model
//   (latency 2, read-during-write returns old data) and a queue-based
//   reference model that is compared against the DUT every cycle.
//   With DATA_TABLE_ARB_LOCK_EN defined the lock port is driven and modelled.
// ---------------------------------------------------------------------------
module tb_data_table_ram_arb;
    import data_table_ram_arb_pkg::*;

    localparam int N   = 4;
    localparam int AW  = 10;
    localparam int DW  = 64;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_mem;
    logic [N-1:0]  lock;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          ram_wr_en;

    int total = 0;
    int bad   = 0;

    data_table_ram_arb_if #(.REQ_CNT(N), .A_WIDTH(AW), .D_WIDTH(DW)) bus ();

    data_table_ram_arb #(
        .REQ_CNT     (N),
        .A_WIDTH     (AW),
        .D_WIDTH     (DW),
        .RAM_LATENCY (LAT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .eng           (bus),
`ifdef DATA_TABLE_ARB_LOCK_EN
        .lock_i        (lock),
`endif
        .ram_rd_addr_o (ram_rd_addr),
        .ram_rd_data_i (ram_rd_data),
        .ram_wr_addr_o (ram_wr_addr),
        .ram_wr_data_o (ram_wr_data),
        .ram_wr_en_o   (ram_wr_en)
    );

    always #5 clk = ~clk;

    // Two-cycle registered-output RAM; read-during-write yields the old word.
    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] ram_q1;
    logic [DW-1:0] ram_q2;

    always @(posedge clk) begin
        ram_q1 <= mem[ram_rd_addr];
        ram_q2 <= ram_q1;
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (ram_wr_en) begin
            mem[ram_wr_addr] <= ram_wr_data;
        end
    end

    assign ram_rd_data = ram_q2;

    // ---------------- reference model state ----------------
    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
    } pend_t;

    pend_t         pend[$];
    logic [DW-1:0] shadow [0:1023];
    int            m_cyc       = 0;
    int            m_rd_ptr    = 0;
    int            m_wr_ptr    = 0;
    bit            m_addr_ok   = 1'b0;
    logic [AW-1:0] m_last_addr = '0;
    bit            m_lock_held = 1'b0;
    int            m_lock_own  = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int off = 0; off < N; off++) begin
            if (req[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [N*AW-1:0] slotA(input int i, input logic [AW-1:0] a);
        logic [N*AW-1:0] v;
        v = '0;
        v[i*AW +: AW] = a;
        return v;
    endfunction

    function automatic logic [N*DW-1:0] slotD(input int i, input logic [DW-1:0] d);
        logic [N*DW-1:0] v;
        v = '0;
        v[i*DW +: DW] = d;
        return v;
    endfunction

    // Cycle-level reference: round-robin by modulo search, shadow memory for
    // read data, and a queue of reads due LAT cycles after their grant.
    task automatic modelProc();
        int            ri;
        int            wi;
        bit            was_held;
        logic [N-1:0]  rq;
        logic [N-1:0]  wq;
        logic [N-1:0]  ev;
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] rv;
        forever begin
            @(negedge clk);
            if (init_mem) begin
                for (int i = 0; i < 1024; i++) shadow[i] = '0;
            end
            rq = bus.rd_req;
            wq = bus.wr_req;
`ifdef DATA_TABLE_ARB_LOCK_EN
            if (m_lock_held) begin
                rq = rq & onehot(m_lock_own);
                wq = wq & onehot(m_lock_own);
            end
`endif
            ri = pick(rq, m_rd_ptr);
            wi = pick(wq, m_wr_ptr);
            ra = (ri >= 0) ? bus.rd_addr[ri*AW +: AW] : '0;
            wa = (wi >= 0) ? bus.wr_addr[wi*AW +: AW] : '0;
            wd = (wi >= 0) ? bus.wr_data[wi*DW +: DW] : '0;

            checkOutput("rd_gnt", 64'(bus.rd_gnt), 64'(onehot(ri)));
            checkOutput("wr_gnt", 64'(bus.wr_gnt), 64'(onehot(wi)));
            checkOutput("wr_en", 64'(ram_wr_en), (wi >= 0) ? 64'd1 : 64'd0);
            checkOutput("wr_addr", 64'(ram_wr_addr), 64'(wa));
            checkOutput("wr_data", ram_wr_data, wd);
            if (ri >= 0) begin
                checkOutput("rd_addr", 64'(ram_rd_addr), 64'(ra));
            end else if (m_addr_ok) begin
                checkOutput("rd_addr_hold", 64'(ram_rd_addr), 64'(m_last_addr));
            end

            ev = '0;
            if (pend.size() > 0 && pend[0].due == m_cyc) begin
                ev = onehot(pend[0].idx);
                checkOutput("rd_data", bus.rd_data, pend[0].data);
                void'(pend.pop_front());
            end
            checkOutput("rd_val", 64'(bus.rd_data_val), 64'(ev));

            // RAM state advances whether or not reset is asserted.
            rv = (ri >= 0) ? shadow[ra] : '0;
            if (wi >= 0) shadow[wa] = wd;

            if (rst) begin
                m_rd_ptr    = 0;
                m_wr_ptr    = 0;
                m_addr_ok   = 1'b0;
                m_lock_held = 1'b0;
                m_lock_own  = 0;
                pend.delete();
            end else begin
                if (ri >= 0) begin
                    pend.push_back('{m_cyc + LAT, ri, rv});
                    m_rd_ptr    = (ri + 1) % N;
                    m_last_addr = ra;
                    m_addr_ok   = 1'b1;
                end
                if (wi >= 0) m_wr_ptr = (wi + 1) % N;
                was_held = m_lock_held;
                if (was_held && !lock[m_lock_own]) m_lock_held = 1'b0;
                if (!was_held) begin
                    if (ri >= 0 && lock[ri]) begin
                        m_lock_held = 1'b1;
                        m_lock_own  = ri;
                    end else if (wi >= 0 && lock[wi]) begin
                        m_lock_held = 1'b1;
                        m_lock_own  = wi;
                    end
                end
            end
            m_cyc++;
        end
    endtask

    // Drives one cycle's inputs just after the rising edge, then settles.
    task automatic applyStimulus(input logic rst_v, input logic [N-1:0] rreq, input logic [N*AW-1:0] raddr,
                                 input logic [N-1:0] wreq, input logic [N*AW-1:0] waddr,
                                 input logic [N*DW-1:0] wdata, input logic [N-1:0] lck);
        @(posedge clk);
        #1;
        rst         = rst_v;
        bus.rd_req  = rreq;
        bus.rd_addr = raddr;
        bus.wr_req  = wreq;
        bus.wr_addr = waddr;
        bus.wr_data = wdata;
        lock        = lck;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0);
    endtask

    localparam logic [DW-1:0] W15 = 64'h0000_1515_AAAA_0015;

    initial begin
        logic [N*AW-1:0] ra;
        logic [N*AW-1:0] wa;
        logic [N*DW-1:0] wd;

        rst         = 1'b1;
        init_mem    = 1'b1;
        lock        = '0;
        bus.rd_req  = '0;
        bus.rd_addr = '0;
        bus.wr_req  = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        fork
            modelProc();
        join_none

        applyStimulus(1'b1, '0, '0, '0, '0, '0, '0);
        applyStimulus(1'b1, '0, '0, '0, '0, '0, '0);
        init_mem = 1'b0;
        applyStimulus(1'b1, '0, '0, '0, '0, '0, '0);

        idle();
        checkOutput("reset_rd_val", 64'(bus.rd_data_val), 64'd0);
        checkOutput("reset_wr_en", 64'(ram_wr_en), 64'd0);

        // Preload 0x15, then engine 2 reads it back.
        applyStimulus(1'b0, '0, '0, 4'b0001, slotA(0, 10'h15), slotD(0, W15), '0);
        checkOutput("pre_wr_gnt", 64'(bus.wr_gnt), 64'b0001);
        checkOutput("pre_wr_addr", 64'(ram_wr_addr), 64'h15);
        applyStimulus(1'b0, 4'b0100, slotA(2, 10'h15), '0, '0, '0, '0);
        checkOutput("single_rd_gnt", 64'(bus.rd_gnt), 64'b0100);
        idle();
        checkOutput("single_early_val", 64'(bus.rd_data_val), 64'd0);
        idle();
        checkOutput("single_rd_val", 64'(bus.rd_data_val), 64'b0100);
        checkOutput("single_rd_data", bus.rd_data, W15);

        // Read granted, then reset the next cycle: no data valid may appear.
        applyStimulus(1'b0, 4'b0010, slotA(1, 10'h3), '0, '0, '0, '0);
        checkOutput("midrst_gnt", 64'(bus.rd_gnt), 64'b0010);
        applyStimulus(1'b1, '0, '0, '0, '0, '0, '0);
        checkOutput("midrst_val0", 64'(bus.rd_data_val), 64'd0);
        idle();
        checkOutput("midrst_val1", 64'(bus.rd_data_val), 64'd0);
        idle();
        checkOutput("midrst_val2", 64'(bus.rd_data_val), 64'd0);

        // Fairness from a fresh pointer: grants and valids rotate 0,1,2,3.
        for (int i = 0; i < 10; i++) begin
            ra = '0;
            for (int e = 0; e < N; e++) ra |= slotA(e, AW'(e + 8));
            applyStimulus(1'b0, (i < 8) ? 4'b1111 : 4'b0000, ra, '0, '0, '0, '0);
            if (i < 8) checkOutput("fair_gnt", 64'(bus.rd_gnt), 64'(onehot(i % 4)));
            if (i >= 2) checkOutput("fair_val", 64'(bus.rd_data_val), 64'(onehot((i - 2) % 4)));
        end

        // Concurrent ports: engine 1 writes while engine 3 reads.
        applyStimulus(1'b0, 4'b1000, slotA(3, 10'h7), 4'b0010, slotA(1, 10'h3), slotD(1, 64'hAB), '0);
        checkOutput("conc_rd_gnt", 64'(bus.rd_gnt), 64'b1000);
        checkOutput("conc_wr_gnt", 64'(bus.wr_gnt), 64'b0010);
        checkOutput("conc_wr_en", 64'(ram_wr_en), 64'd1);
        checkOutput("conc_wr_addr", 64'(ram_wr_addr), 64'h3);
        checkOutput("conc_wr_data", ram_wr_data, 64'hAB);
        idle();
        idle();
        checkOutput("conc_rd_val", 64'(bus.rd_data_val), 64'b1000);

        // Read-during-write returns the old word; the next read sees the new.
        applyStimulus(1'b0, '0, '0, 4'b0001, slotA(0, 10'h5), slotD(0, 64'h11), '0);
        applyStimulus(1'b0, 4'b0010, slotA(1, 10'h5), 4'b0001, slotA(0, 10'h5), slotD(0, 64'h22), '0);
        applyStimulus(1'b0, 4'b0100, slotA(2, 10'h5), '0, '0, '0, '0);
        idle();
        checkOutput("rdw_old_val", 64'(bus.rd_data_val), 64'b0010);
        checkOutput("rdw_old_data", bus.rd_data, 64'h11);
        idle();
        checkOutput("rdw_new_val", 64'(bus.rd_data_val), 64'b0100);
        checkOutput("rdw_new_data", bus.rd_data, 64'h22);

`ifdef DATA_TABLE_ARB_LOCK_EN
        // Engine 3 takes the lock; engine 0 waits until it is released.
        applyStimulus(1'b0, 4'b1000, '0, '0, '0, '0, 4'b1000);
        checkOutput("lock_take", 64'(bus.rd_gnt), 64'b1000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'b1001, '0, '0, '0, '0, 4'b1000);
            checkOutput("lock_hold", 64'(bus.rd_gnt), 64'b1000);
        end
        applyStimulus(1'b0, 4'b1001, '0, '0, '0, '0, 4'b0000);
        applyStimulus(1'b0, 4'b1001, '0, '0, '0, '0, 4'b0000);
        checkOutput("lock_release", 64'(bus.rd_gnt), 64'b0001);
        idle();
        idle();
`endif

        // Randomised traffic on a small address window to force collisions.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                applyStimulus(1'b1, '0, '0, '0, '0, '0, '0);
            end else begin
                ra = '0;
                wa = '0;
                wd = '0;
                for (int e = 0; e < N; e++) begin
                    ra |= slotA(e, AW'($urandom_range(0, 15)));
                    wa |= slotA(e, AW'($urandom_range(0, 15)));
                    wd |= slotD(e, {$urandom, $urandom});
                end
                applyStimulus(1'b0, N'($urandom_range(0, 15)), ra, N'($urandom_range(0, 15)), wa, wd,
                              N'($urandom & $urandom & $urandom));
            end
        end

        repeat (4) idle();
        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
